aes_decrypt_core: RTL
=====================

// Module: aes_decrypt_core
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197 InvCipher); one round per clock.
//  Companion to fn_aes_encrypt_stage: same 128-bit state layout, same 1408-bit key schedule.
//  Accepts a ciphertext block plus its expanded key schedule over a valid/ready handshake.
//  Returns the plaintext over a second valid/ready handshake. One block in flight at a time.
// PARAMETERS
//  NR        10     number of AES rounds (AES-128); key schedule width is (NR+1)*128
//  KS_WIDTH  1408   key schedule width, (NR+1)*128
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  in_valid      in   1         ciphertext and key schedule valid
//  in_ready      out  1         core idle; can accept a block
//  in_data       in   [0:127]   ciphertext block
//  key_schedule  in   [0:1407]  round keys; round key r = key_schedule[r*128 +:128]
//  out_valid     out  1         plaintext valid
//  out_ready     in   1         consumer accepts plaintext
//  out_data      out  [0:127]   plaintext block
//  busy          out  1         high in RUN and DONE
// BEHAVIOUR
//  State layout
//  - MSB-first [0:127]; byte k = bits [8k +:8].
//  - Column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//  - IDLE: in_ready=1. On in_valid & in_ready at edge T:
//    - key_schedule is latched into an internal register;
//    - state <= in_data ^ rk[NR]; rnd <= NR-1; go to RUN.
//  - RUN: one round per edge, using the latched keys (inputs are ignored while busy).
//    - rnd>0: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]); rnd <= rnd-1.
//    - rnd==0: out_data <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go to DONE.
//  - DONE: out_valid=1 and out_data held stable until out_valid & out_ready.
//    - On that handshake go to IDLE; in_ready rises the next cycle. No back-to-back overlap.
//  Latency
//  - out_valid is first seen high after edge T+NR (10 cycles after acceptance).
//  - Throughput: one block per NR+2 cycles when out_ready is held high.
//  InvShiftRows
//  - Row r is rotated right by r columns: new[col c,row r] = old[col (c-r) mod 4, row r].
//  InvSubBytes
//  - 256-entry inverse S-box, combinational lookup on each of the 16 bytes.
//  InvMixColumns
//  - Each column is multiplied by the circulant matrix [0e 0b 0d 09] in GF(2^8), poly 0x11B.
//  - xtime(b) = (b<<1) ^ (b[MSB] ? 8'h1B : 0), truncated to 8 bits.
//  - x9 = x8^x; x11 = x8^x2^x; x13 = x8^x4^x; x14 = x8^x4^x2.
//  - InvMixColumns is not applied in the final round (rnd==0).
//  Round counter
//  - rnd is 4 bits, counts NR-1 down to 0, never wraps; it is held in IDLE and DONE.
//  Simultaneous events
//  - in_valid is ignored outside IDLE.
//  - out_ready is ignored unless out_valid is high.
//  - in_valid high in the same cycle as the DONE handshake is not accepted until IDLE.
//  Reset (asynchronous, any time including mid-RUN)
//  - state returns to IDLE; in-flight block discarded.
//  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0.
//  - Internal state register, rnd and the latched key schedule are cleared to 0.
// TESTING
//  1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//     -> out_data 3243f6a8885a308d313198a2e0370734; out_valid 10 cycles after acceptance.
//  2. FIPS-197 App. C.1: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//     -> out_data 00112233445566778899aabbccddeeff.
//  3. Backpressure: hold out_ready=0 for 20 cycles after out_valid
//     -> out_data stable, in_ready=0, busy=1 throughout; exactly one transfer on release.
//  4. Busy input: pulse in_valid with a new block while in RUN
//     -> ignored; output equals the first block; second block accepted only once in IDLE.
//  5. Reset mid-RUN: assert rst_n=0 at round 5
//     -> out_valid=0, out_data=0, in_ready=1 immediately; next block (vector 1) decrypts correctly.
//  6. Round trip: 200 random key/plaintext pairs, encrypted with the fn_aes_encrypt_stage flow
//     and fed back in -> recovered plaintext equals the original, out_ready randomly toggled.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one round per clock, one block in flight.
// The 128-bit state is MSB-first; byte k sits at bits [8k +: 8], and
// column c holds bytes 4c..4c+3 (row r of column c is byte 4c+r).
// The inverse S-box is derived arithmetically (inverse affine map followed
// by the GF(2^8) multiplicative inverse) rather than stored as a table.
module aes_decrypt_core #(
  parameter int NR       = 10,
  parameter int KS_WIDTH = (NR + 1) * 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:127]        in_data,
  input  logic [0:KS_WIDTH-1] key_schedule,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:127]        out_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [0:127]        blk_q;
  logic [3:0]          rnd_q;
  logic [0:KS_WIDTH-1] key_q;
  logic [0:127]        out_q;
  logic [0:127]        round_key;
  logic [0:127]        sub_c;
  logic [0:127]        add_c;
  logic [0:127]        mix_c;
  logic                accept;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x127;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x126 = gf_mul(x120, x6);
    x127 = gf_mul(x126, a);
    return gf_mul(x127, x127);
  endfunction

  // Undo the S-box affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Column times circulant [0e 0b 0d 09], built from an xtime chain
  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   x2, x4, x8;
    logic [7:0]   m9 [4];
    logic [7:0]   m11[4];
    logic [7:0]   m13[4];
    logic [7:0]   m14[4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        x2     = xtime(s[8*(4*c+i) +: 8]);
        x4     = xtime(x2);
        x8     = xtime(x4);
        m9[i]  = x8 ^ s[8*(4*c+i) +: 8];
        m11[i] = x8 ^ x2 ^ s[8*(4*c+i) +: 8];
        m13[i] = x8 ^ x4 ^ s[8*(4*c+i) +: 8];
        m14[i] = x8 ^ x4 ^ x2;
      end
      for (int i = 0; i < 4; i++) begin
        o[8*(4*c+i) +: 8] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];
      end
    end
    return o;
  endfunction

  assign accept = (fsm_q == IDLE) && in_valid;

  // Select the round key for the current round from the latched schedule
  always_comb begin
    round_key = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rnd_q == 4'(r)) round_key = key_q[r*128 +: 128];
    end
  end

  // One inverse round; the mix step is only used while rnd is nonzero
  always_comb begin
    sub_c = inv_sub_bytes(inv_shift_rows(blk_q));
    add_c = sub_c ^ round_key;
    mix_c = inv_mix_columns(add_c);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = RUN;
      RUN:     if (rnd_q == 4'd0) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Key latch, initial whitening, round iteration and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      rnd_q <= '0;
      key_q <= '0;
      out_q <= '0;
    end else if (accept) begin
      key_q <= key_schedule;
      blk_q <= in_data ^ key_schedule[NR*128 +: 128];
      rnd_q <= 4'(NR - 1);
    end else if (fsm_q == RUN) begin
      if (rnd_q != 4'd0) begin
        blk_q <= mix_c;
        rnd_q <= rnd_q - 4'd1;
      end else begin
        out_q <= add_c;
      end
    end
  end

  assign out_data = out_q;

endmodule
